// File: rtl/wso_capture_checker.sv
// Wrapper serial-out capture: deserializes an LSB-first WSO frame of 1..SIZE bits
// and compares it against a masked expected word, tracking sticky failures.
module wso_capture_checker #(
  parameter int SIZE  = 12,
  parameter int CNT_W = 4
) (
  input  logic             WRCK,
  input  logic             RESET,
  input  logic             ShiftWR,
  input  logic             WSO,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] length,
  input  logic [SIZE-1:0]  exp_data,
  input  logic [SIZE-1:0]  exp_mask,
  input  logic             clr_fail,
  output logic             busy,
  output logic [SIZE-1:0]  data_out,
  output logic             data_valid,
  output logic             mismatch,
  output logic             fail,
  output logic [7:0]       fail_cnt,
  output logic             len_err
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0]  shift_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [SIZE-1:0]  exp_p0;
  logic [SIZE-1:0]  mask_p0;
  logic [CNT_W-1:0] len_p0;

  logic             len_ok;
  logic             in_frame;
  logic             last_bit;
  logic             sample;
  logic             finish;
  logic             accept;
  logic             reject;
  logic [SIZE-1:0]  frame_d;
  logic [SIZE-1:0]  lmask;
  logic             miss_d;
  logic [7:0]       cnt_base;

  function automatic logic [SIZE-1:0] len_mask(input logic [CNT_W-1:0] len);
    logic [SIZE-1:0] m;
    for (int i = 0; i < SIZE; i++) begin
      m[i] = (CNT_W'(i) < len);
    end
    return m;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign len_ok   = (length != '0) && (length <= CNT_W'(SIZE));
  assign in_frame = (state_q == ARMED) || (state_q == SHIFT);
  assign last_bit = ((cnt_p0 + CNT_W'(1)) == len_p0);
  // abort wins over a sample on the same edge, including the final bit
  assign sample   = in_frame && ShiftWR && !abort;
  assign finish   = sample && last_bit;
  assign accept   = (state_q == IDLE) && start && len_ok;
  assign reject   = (state_q == IDLE) && start && !len_ok;
  assign busy     = in_frame;

  always_comb begin
    frame_d = shift_p0;
    for (int i = 0; i < SIZE; i++) begin
      if (CNT_W'(i) == cnt_p0) frame_d[i] = WSO;
    end
  end

  assign lmask    = len_mask(len_p0);
  assign miss_d   = |((frame_d ^ exp_p0) & mask_p0 & lmask);
  assign cnt_base = clr_fail ? 8'd0 : fail_cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ARMED;
      ARMED: begin
        if (abort)        state_d = IDLE;
        else if (finish)  state_d = DONE;
        else if (sample)  state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)        state_d = IDLE;
        else if (finish)  state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // capture stage: frame shift register, bit counter and latched compare setup
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      shift_p0 <= '0;
      cnt_p0   <= '0;
      exp_p0   <= '0;
      mask_p0  <= '0;
      len_p0   <= '0;
    end else if (accept) begin
      shift_p0 <= '0;
      cnt_p0   <= '0;
      exp_p0   <= exp_data;
      mask_p0  <= exp_mask;
      len_p0   <= length;
    end else if (sample) begin
      shift_p0 <= frame_d;
      cnt_p0   <= cnt_p0 + CNT_W'(1);
    end
  end

  // result stage: registered on the edge entering DONE
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      mismatch   <= 1'b0;
      fail       <= 1'b0;
      fail_cnt   <= 8'd0;
      len_err    <= 1'b0;
    end else begin
      data_valid <= finish;
      len_err    <= reject;
      if (finish) begin
        data_out <= frame_d & lmask;
        mismatch <= miss_d;
      end
      fail     <= (fail && !clr_fail) || (finish && miss_d);
      fail_cnt <= (finish && miss_d) ? sat_inc(cnt_base) : cnt_base;
    end
  end

endmodule

// File: tb/tb_wso_capture_checker.sv
// Directed bench for wso_capture_checker: framing, compare, sticky fail, pause, abort, bypass.
module tb_wso_capture_checker;

  logic        WRCK = 1'b0;
  logic        RESET, ShiftWR, WSO, start, abort, clr_fail;
  logic [3:0]  length;
  logic [11:0] exp_data, exp_mask;
  logic        busy, data_valid, mismatch, fail, len_err;
  logic [11:0] data_out;
  logic [7:0]  fail_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  wso_capture_checker #(.SIZE(12), .CNT_W(4)) dut (
    .WRCK(WRCK), .RESET(RESET), .ShiftWR(ShiftWR), .WSO(WSO),
    .start(start), .abort(abort), .length(length),
    .exp_data(exp_data), .exp_mask(exp_mask), .clr_fail(clr_fail),
    .busy(busy), .data_out(data_out), .data_valid(data_valid),
    .mismatch(mismatch), .fail(fail), .fail_cnt(fail_cnt), .len_err(len_err)
  );

  always #5 WRCK = ~WRCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic arm(input logic [3:0] len, input logic [11:0] e, input logic [11:0] m);
    start = 1'b1; length = len; exp_data = e; exp_mask = m;
    @(negedge WRCK);
    start = 1'b0;
  endtask

  task automatic shift_n(input logic [11:0] bits, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      ShiftWR = 1'b1; WSO = bits[k];
      @(negedge WRCK);
    end
    ShiftWR = 1'b0; WSO = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge WRCK);
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (data_out !== 12'h000) begin n_fail++; $display("FAIL rst_data: got %h want 000", data_out); end
    n_vec++; if ({data_valid, mismatch, fail, len_err} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_flags: got %b want 0000", {data_valid, mismatch, fail, len_err}); end
    n_vec++; if (fail_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", fail_cnt); end
    RESET = 1'b0;
    @(negedge WRCK);
  endtask

  task automatic test_match;
    arm(4'd12, 12'h492, 12'hFFF);
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL armed_busy: got %b want 1", busy); end
    shift_n(12'h492, 0, 11);
    n_vec++; if ({busy, data_valid} !== 2'b10) begin n_fail++;
      $display("FAIL match_pre: busy,dv got %b want 10", {busy, data_valid}); end
    shift_n(12'h492, 11, 1);
    n_vec++; if ({busy, data_valid, mismatch, fail} !== 4'b0100) begin n_fail++;
      $display("FAIL match_flags: busy,dv,mis,fail got %b want 0100", {busy, data_valid, mismatch, fail}); end
    n_vec++; if (data_out !== 12'h492) begin n_fail++; $display("FAIL match_data: got %h want 492", data_out); end
    @(negedge WRCK);
    n_vec++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL match_pulse: dv got %b want 0", data_valid); end
  endtask

  task automatic test_mismatch;
    arm(4'd12, 12'h492, 12'hFFF);
    shift_n(12'h4B2, 0, 12);
    n_vec++; if ({data_valid, mismatch, fail} !== 3'b111 || fail_cnt !== 8'd1) begin n_fail++;
      $display("FAIL bad1: dv,mis,fail got %b cnt %0d want 111 cnt 1", {data_valid, mismatch, fail}, fail_cnt); end
    n_vec++; if (data_out !== 12'h4B2) begin n_fail++; $display("FAIL bad1_data: got %h want 4b2", data_out); end
    @(negedge WRCK);
    n_vec++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mis_hold: got %b want 1", mismatch); end
    arm(4'd12, 12'h492, 12'hFFF);
    shift_n(12'h4B2, 0, 12);
    n_vec++; if (fail_cnt !== 8'd2) begin n_fail++; $display("FAIL bad2_cnt: got %0d want 2", fail_cnt); end
    @(negedge WRCK);
    clr_fail = 1'b1;
    @(negedge WRCK);
    clr_fail = 1'b0;
    n_vec++; if (fail !== 1'b0 || fail_cnt !== 8'd0) begin n_fail++;
      $display("FAIL clr: fail %b cnt %0d want 0 0", fail, fail_cnt); end
    arm(4'd12, 12'h492, 12'hFDF);
    shift_n(12'h4B2, 0, 12);
    n_vec++; if ({data_valid, mismatch, fail} !== 3'b100) begin n_fail++;
      $display("FAIL masked: dv,mis,fail got %b want 100", {data_valid, mismatch, fail}); end
    @(negedge WRCK);
    arm(4'd12, 12'h492, 12'hFFF);
    shift_n(12'h4B2, 0, 12);
    @(negedge WRCK);
    arm(4'd12, 12'h492, 12'hFFF);
    shift_n(12'h4B2, 0, 11);
    clr_fail = 1'b1;
    shift_n(12'h4B2, 11, 1);
    clr_fail = 1'b0;
    n_vec++; if (fail !== 1'b1 || fail_cnt !== 8'd1) begin n_fail++;
      $display("FAIL clr_and_bad: fail %b cnt %0d want 1 1", fail, fail_cnt); end
    @(negedge WRCK);
  endtask

  task automatic test_pause;
    arm(4'd4, 12'hFFB, 12'hFFF);
    shift_n(12'h00B, 0, 2);
    WSO = 1'b1;
    repeat (3) @(negedge WRCK);
    n_vec++; if ({busy, data_valid} !== 2'b10) begin n_fail++;
      $display("FAIL pause: busy,dv got %b want 10", {busy, data_valid}); end
    shift_n(12'h00B, 2, 2);
    n_vec++; if ({data_valid, mismatch} !== 2'b10) begin n_fail++;
      $display("FAIL pause_done: dv,mis got %b want 10", {data_valid, mismatch}); end
    n_vec++; if (data_out !== 12'h00B) begin n_fail++; $display("FAIL pause_data: got %h want 00b", data_out); end
    @(negedge WRCK);
  endtask

  task automatic test_len_err;
    start = 1'b1; length = 4'd0;
    @(negedge WRCK);
    start = 1'b0;
    n_vec++; if ({len_err, busy} !== 2'b10) begin n_fail++;
      $display("FAIL len0: len_err,busy got %b want 10", {len_err, busy}); end
    @(negedge WRCK);
    n_vec++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL len_pulse: got %b want 0", len_err); end
    start = 1'b1; length = 4'd13;
    @(negedge WRCK);
    start = 1'b0;
    n_vec++; if ({len_err, busy} !== 2'b10) begin n_fail++;
      $display("FAIL len13: len_err,busy got %b want 10", {len_err, busy}); end
    @(negedge WRCK);
  endtask

  task automatic test_busy_abort;
    arm(4'd12, 12'h000, 12'hFFF);
    shift_n(12'hABC, 0, 2);
    start = 1'b1; length = 4'd0;
    @(negedge WRCK);
    start = 1'b0;
    n_vec++; if ({len_err, busy} !== 2'b01) begin n_fail++;
      $display("FAIL start_busy: len_err,busy got %b want 01", {len_err, busy}); end
    shift_n(12'hABC, 2, 4);
    abort = 1'b1;
    @(negedge WRCK);
    abort = 1'b0;
    n_vec++; if ({busy, data_valid} !== 2'b00 || data_out !== 12'h00B) begin n_fail++;
      $display("FAIL abort: busy,dv %b data %h want 00 00b", {busy, data_valid}, data_out); end
    @(negedge WRCK);
    n_vec++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL abort_dv: got %b want 0", data_valid); end
    arm(4'd2, 12'h000, 12'h003);
    shift_n(12'h003, 0, 1);
    ShiftWR = 1'b1; WSO = 1'b1; abort = 1'b1;
    @(negedge WRCK);
    ShiftWR = 1'b0; abort = 1'b0;
    n_vec++; if ({busy, data_valid} !== 2'b00 || data_out !== 12'h00B || fail_cnt !== 8'd1) begin n_fail++;
      $display("FAIL abort_last: busy,dv %b data %h cnt %0d want 00 00b 1", {busy, data_valid}, data_out, fail_cnt); end
    @(negedge WRCK);
  endtask

  task automatic test_len1;
    arm(4'd1, 12'hFFF, 12'hFFF);
    shift_n(12'h001, 0, 1);
    n_vec++; if ({data_valid, mismatch} !== 2'b10 || data_out !== 12'h001) begin n_fail++;
      $display("FAIL len1: dv,mis %b data %h want 10 001", {data_valid, mismatch}, data_out); end
    @(negedge WRCK);
  endtask

  task automatic test_bypass;
    logic [11:0] wsi;
    logic        wby;
    wsi = 12'h492;
    wby = 1'b0;
    arm(4'd12, 12'h924, 12'hFFF);
    for (int k = 0; k < 12; k++) begin
      ShiftWR = 1'b1; WSO = wby; wby = wsi[k];
      @(negedge WRCK);
    end
    ShiftWR = 1'b0; WSO = 1'b0;
    n_vec++; if ({data_valid, mismatch} !== 2'b10 || data_out !== 12'h924) begin n_fail++;
      $display("FAIL bypass: dv,mis %b data %h want 10 924", {data_valid, mismatch}, data_out); end
    @(negedge WRCK);
  endtask

  task automatic test_reset_mid;
    arm(4'd12, 12'h492, 12'hFFF);
    shift_n(12'h4B2, 0, 12);
    @(negedge WRCK);
    arm(4'd12, 12'h492, 12'hFFF);
    shift_n(12'h4B2, 0, 5);
    n_vec++; if (busy !== 1'b1 || fail !== 1'b1) begin n_fail++;
      $display("FAIL pre_reset: busy %b fail %b want 1 1", busy, fail); end
    #2 RESET = 1'b1;
    #1;
    n_vec++; if ({busy, data_valid, mismatch, fail} !== 4'b0000 || fail_cnt !== 8'd0 || data_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: busy,dv,mis,fail %b cnt %0d data %h want 0000 0 000",
               {busy, data_valid, mismatch, fail}, fail_cnt, data_out);
    end
    @(negedge WRCK);
    RESET = 1'b0;
    @(negedge WRCK);
  endtask

  initial begin
    RESET = 1'b1; ShiftWR = 1'b0; WSO = 1'b0; start = 1'b0; abort = 1'b0; clr_fail = 1'b0;
    length = 4'd0; exp_data = 12'h000; exp_mask = 12'h000;
    test_reset();
    test_match();
    test_mismatch();
    test_pause();
    test_len_err();
    test_busy_abort();
    test_len1();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
